// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for a 5-stage RISC-V pipeline.
// It resolves load-use hazards, branches taken in ID and a fixed-latency
// multiply that occupies EX. It also keeps stall and flush counters.
module pipeline_ctrl #(
  parameter int MUL_LAT = 4,   // total EX cycles of a multiply, 1..16
  parameter int CNT_W   = 32   // performance counter width
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [4:0]       IFID_RS1addr_i,
  input  logic [4:0]       IFID_RS2addr_i,
  input  logic             IFID_useRS2_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_RDaddr_i,
  input  logic             IDEX_mul_i,
  input  logic             branch_taken_i,
  output logic             PCWrite_o,
  output logic             IFID_write_o,
  output logic             IFID_flush_o,
  output logic             IDEX_bubble_o,
  output logic             IDEX_hold_o,
  output logic             EXMEM_bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MUL_WAIT = 2'd2
  } state_t;

  // The cycle that enters MUL_WAIT is already the first of MUL_LAT EX cycles.
  localparam logic [3:0] MCNT_INIT = 4'(MUL_LAT - 1);
  localparam bit         MUL_STALL = (MUL_LAT > 1);

  state_t     state, state_nxt;
  logic [3:0] mcnt, mcnt_nxt;
  logic       load_use;

  // A load in EX whose rd (x0 excluded) feeds a source that ID actually reads.
  function automatic logic load_use_hit(
    input logic       mem_read,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       use_rs2
  );
    load_use_hit = mem_read && (rd != 5'd0) &&
                   ((rd == rs1) || (use_rs2 && (rd == rs2)));
  endfunction

  // Increment with natural wrap modulo 2^CNT_W.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    cnt_inc = c + CNT_W'(1);
  endfunction

  assign load_use = load_use_hit(IDEX_MemRead_i, IDEX_RDaddr_i,
                                 IFID_RS1addr_i, IFID_RS2addr_i, IFID_useRS2_i);

  // State register and multiply down-counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      mcnt  <= 4'd0;
    end else begin
      state <= state_nxt;
      mcnt  <= mcnt_nxt;
    end
  end

  // Next state and combinational pipeline controls.
  always_comb begin
    state_nxt      = state;
    mcnt_nxt       = mcnt;
    PCWrite_o      = 1'b1;
    IFID_write_o   = 1'b1;
    IFID_flush_o   = 1'b0;
    IDEX_bubble_o  = 1'b0;
    IDEX_hold_o    = 1'b0;
    EXMEM_bubble_o = 1'b0;

    case (state)
      IDLE: begin
        PCWrite_o      = 1'b0;
        IFID_write_o   = 1'b0;
        IDEX_bubble_o  = 1'b1;
        EXMEM_bubble_o = 1'b1;
        if (start_i) state_nxt = RUN;
      end

      RUN: begin
        if (IDEX_mul_i && MUL_STALL) begin
          PCWrite_o      = 1'b0;
          IFID_write_o   = 1'b0;
          IDEX_hold_o    = 1'b1;
          EXMEM_bubble_o = 1'b1;
          state_nxt      = MUL_WAIT;
          mcnt_nxt       = MCNT_INIT;
        end else if (load_use) begin
          PCWrite_o     = 1'b0;
          IFID_write_o  = 1'b0;
          IDEX_bubble_o = 1'b1;
        end else if (branch_taken_i) begin
          IFID_flush_o = 1'b1;
        end
      end

      MUL_WAIT: begin
        if (mcnt > 4'd1) begin
          // MUL still busy in EX: freeze the front end, ID is ignored.
          PCWrite_o      = 1'b0;
          IFID_write_o   = 1'b0;
          IDEX_hold_o    = 1'b1;
          EXMEM_bubble_o = 1'b1;
          mcnt_nxt       = mcnt - 4'd1;
        end else begin
          // Release cycle: MUL result moves on, ID gets normal hazard rules.
          if (load_use) begin
            PCWrite_o     = 1'b0;
            IFID_write_o  = 1'b0;
            IDEX_bubble_o = 1'b1;
          end else if (branch_taken_i) begin
            IFID_flush_o = 1'b1;
          end
          state_nxt = RUN;
          mcnt_nxt  = 4'd0;
        end
      end

      default: begin
        state_nxt = IDLE;
        mcnt_nxt  = 4'd0;
      end
    endcase

    // Dropping the run enable wins over everything, aborting any multiply.
    if (!start_i) begin
      state_nxt = IDLE;
      mcnt_nxt  = 4'd0;
    end
  end

  // Stall and flush performance counters; both hold while idle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if ((state != IDLE) && !PCWrite_o) stall_cnt_o <= cnt_inc(stall_cnt_o);
      if (IFID_flush_o) flush_cnt_o <= cnt_inc(flush_cnt_o);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed table-driven bench for pipeline_ctrl.
module tb_pipeline_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic [4:0] IFID_RS1addr_i, IFID_RS2addr_i, IDEX_RDaddr_i;
  logic       IFID_useRS2_i, IDEX_MemRead_i, IDEX_mul_i, branch_taken_i;

  logic       PCWrite_o, IFID_write_o, IFID_flush_o;
  logic       IDEX_bubble_o, IDEX_hold_o, EXMEM_bubble_o;
  logic [7:0] stall_cnt_o, flush_cnt_o;

  logic       d1_pcw, d1_ifw, d1_flush, d1_bub, d1_hold, d1_exb;
  logic [7:0] d1_stall_cnt, d1_flush_cnt;

  pipeline_ctrl #(.MUL_LAT(4), .CNT_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .IFID_RS1addr_i(IFID_RS1addr_i), .IFID_RS2addr_i(IFID_RS2addr_i),
    .IFID_useRS2_i(IFID_useRS2_i), .IDEX_MemRead_i(IDEX_MemRead_i),
    .IDEX_RDaddr_i(IDEX_RDaddr_i), .IDEX_mul_i(IDEX_mul_i),
    .branch_taken_i(branch_taken_i),
    .PCWrite_o(PCWrite_o), .IFID_write_o(IFID_write_o),
    .IFID_flush_o(IFID_flush_o), .IDEX_bubble_o(IDEX_bubble_o),
    .IDEX_hold_o(IDEX_hold_o), .EXMEM_bubble_o(EXMEM_bubble_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  // Single-cycle multiply build: must never stall on MUL.
  pipeline_ctrl #(.MUL_LAT(1), .CNT_W(8)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .IFID_RS1addr_i(IFID_RS1addr_i), .IFID_RS2addr_i(IFID_RS2addr_i),
    .IFID_useRS2_i(IFID_useRS2_i), .IDEX_MemRead_i(IDEX_MemRead_i),
    .IDEX_RDaddr_i(IDEX_RDaddr_i), .IDEX_mul_i(IDEX_mul_i),
    .branch_taken_i(branch_taken_i),
    .PCWrite_o(d1_pcw), .IFID_write_o(d1_ifw),
    .IFID_flush_o(d1_flush), .IDEX_bubble_o(d1_bub),
    .IDEX_hold_o(d1_hold), .EXMEM_bubble_o(d1_exb),
    .stall_cnt_o(d1_stall_cnt), .flush_cnt_o(d1_flush_cnt)
  );

  always #5 clk_i = ~clk_i;

  // Output bundle order: {PCWrite, IFID_write, IFID_flush, IDEX_bubble, IDEX_hold, EXMEM_bubble}
  logic [5:0] outs, outs1;
  assign outs  = {PCWrite_o, IFID_write_o, IFID_flush_o, IDEX_bubble_o, IDEX_hold_o, EXMEM_bubble_o};
  assign outs1 = {d1_pcw, d1_ifw, d1_flush, d1_bub, d1_hold, d1_exb};

  localparam logic [5:0] O_IDLE  = 6'b000101;
  localparam logic [5:0] O_RUN   = 6'b110000;
  localparam logic [5:0] O_LU    = 6'b000100;
  localparam logic [5:0] O_FLUSH = 6'b111000;
  localparam logic [5:0] O_MUL   = 6'b000011;

  typedef struct packed {
    logic       mr;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use2;
    logic       br;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs [10];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] exp_stall, exp_flush;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    IFID_RS1addr_i = 5'd0;
    IFID_RS2addr_i = 5'd0;
    IDEX_RDaddr_i  = 5'd0;
    IFID_useRS2_i  = 1'b0;
    IDEX_MemRead_i = 1'b0;
    IDEX_mul_i     = 1'b0;
    branch_taken_i = 1'b0;
  endtask

  task automatic set_id(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic use2, input logic br);
    IDEX_MemRead_i = mr;
    IDEX_RDaddr_i  = rd;
    IFID_RS1addr_i = rs1;
    IFID_RS2addr_i = rs2;
    IFID_useRS2_i  = use2;
    branch_taken_i = br;
  endtask

  // Reset, then raise start and land in RUN.
  task automatic reset_and_start();
    rst_i   = 1'b0;
    start_i = 1'b0;
    clear_inputs();
    step();
    step();
    rst_i = 1'b1;
    step();
    start_i = 1'b1;
    step();
  endtask

  initial begin
    //            mr  rd     rs1    rs2    use2  br    expected
    vecs[0] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, O_RUN};
    vecs[1] = '{1'b1, 5'd5,  5'd5,  5'd1,  1'b0, 1'b0, O_LU};
    vecs[2] = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, O_RUN};
    vecs[3] = '{1'b1, 5'd7,  5'd3,  5'd7,  1'b0, 1'b0, O_RUN};
    vecs[4] = '{1'b1, 5'd7,  5'd3,  5'd7,  1'b1, 1'b0, O_LU};
    vecs[5] = '{1'b0, 5'd5,  5'd5,  5'd5,  1'b1, 1'b0, O_RUN};
    vecs[6] = '{1'b0, 5'd0,  5'd2,  5'd4,  1'b1, 1'b1, O_FLUSH};
    vecs[7] = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b0, 1'b1, O_LU};
    vecs[8] = '{1'b1, 5'd6,  5'd5,  5'd9,  1'b1, 1'b1, O_FLUSH};
    vecs[9] = '{1'b1, 5'd9,  5'd9,  5'd9,  1'b0, 1'b0, O_LU};

    // Reset state and IDLE outputs before start.
    rst_i   = 1'b0;
    start_i = 1'b0;
    clear_inputs();
    step();
    check("reset_outs", 32'(outs), 32'(O_IDLE));
    check("reset_stall_cnt", 32'(stall_cnt_o), 32'd0);
    check("reset_flush_cnt", 32'(flush_cnt_o), 32'd0);
    rst_i = 1'b1;
    step();
    check("idle_outs", 32'(outs), 32'(O_IDLE));
    start_i = 1'b1;
    step();
    check("run_after_start", 32'(outs), 32'(O_RUN));

    // Single-cycle hazard table in RUN.
    exp_stall = 8'd0;
    exp_flush = 8'd0;
    for (int i = 0; i < 10; i++) begin
      set_id(vecs[i].mr, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].use2, vecs[i].br);
      #1;
      check($sformatf("vec%0d", i), 32'(outs), 32'(vecs[i].exp));
      exp_stall = exp_stall + 8'(!vecs[i].exp[5]);
      exp_flush = exp_flush + 8'(vecs[i].exp[3]);
      step();
    end
    clear_inputs();
    check("table_stall_cnt", 32'(stall_cnt_o), 32'(exp_stall));
    check("table_flush_cnt", 32'(flush_cnt_o), 32'(exp_flush));

    // Load-use stall then flush from the re-evaluated branch.
    reset_and_start();
    set_id(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1);
    #1;
    check("lu_br_stall", 32'(outs), 32'(O_LU));
    step();
    check("lu_br_stall_cnt", 32'(stall_cnt_o), 32'd1);
    set_id(1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b1);
    #1;
    check("lu_br_flush", 32'(outs), 32'(O_FLUSH));
    step();
    clear_inputs();
    check("lu_br_flush_cnt", 32'(flush_cnt_o), 32'd1);

    // MUL_LAT=4 multiply with a branch pulse at cycle 1.
    reset_and_start();
    IDEX_mul_i = 1'b1;
    #1;
    check("mul_c0", 32'(outs), 32'(O_MUL));
    check("mul1_c0_no_stall", 32'(outs1), 32'(O_RUN));
    step();
    branch_taken_i = 1'b1;
    #1;
    check("mul_c1_br_ignored", 32'(outs), 32'(O_MUL));
    step();
    branch_taken_i = 1'b0;
    check("mul_c2", 32'(outs), 32'(O_MUL));
    step();
    check("mul_c3_release", 32'(outs), 32'(O_RUN));
    step();
    IDEX_mul_i = 1'b0;
    #1;
    check("mul_after", 32'(outs), 32'(O_RUN));
    check("mul_stall_cnt", 32'(stall_cnt_o), 32'd3);
    check("mul_flush_cnt", 32'(flush_cnt_o), 32'd0);
    check("mul1_stall_cnt", 32'(d1_stall_cnt), 32'd0);
    check("mul1_flush_cnt", 32'(d1_flush_cnt), 32'd1);

    // start_i dropped at cycle 1 of a multiply.
    reset_and_start();
    IDEX_mul_i = 1'b1;
    step();
    start_i = 1'b0;
    #1;
    check("abort_c1_outs", 32'(outs), 32'(O_MUL));
    step();
    IDEX_mul_i = 1'b0;
    check("abort_idle_outs", 32'(outs), 32'(O_IDLE));
    check("abort_mcnt", 32'(dut.mcnt), 32'd0);
    start_i = 1'b1;
    step();
    check("abort_restart", 32'(outs), 32'(O_RUN));

    // Asynchronous reset in the middle of a multiply.
    reset_and_start();
    IDEX_mul_i = 1'b1;
    step();
    step();
    check("rstmul_stall_cnt", 32'(stall_cnt_o), 32'd2);
    #1;
    rst_i = 1'b0;
    #1;
    check("rstmul_outs", 32'(outs), 32'(O_IDLE));
    check("rstmul_cnt_clr", 32'(stall_cnt_o), 32'd0);
    check("rstmul_mcnt", 32'(dut.mcnt), 32'd0);
    #1;
    rst_i = 1'b1;
    IDEX_mul_i = 1'b0;
    step();
    check("rstmul_restart", 32'(outs), 32'(O_RUN));

    // Stall counter wrap on the 8-bit build.
    reset_and_start();
    set_id(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 255; i++) step();
    check("wrap_max", 32'(stall_cnt_o), 32'd255);
    step();
    check("wrap_zero", 32'(stall_cnt_o), 32'd0);
    clear_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives PC write-enable, IF/ID write/flush, ID/EX bubble/hold and EX/MEM bubble.
- Resolves load-use hazards, branches taken in ID, and a fixed-latency multi-cycle multiply occupying EX.
- Keeps stall and flush performance counters.

Parameters:
MUL_LAT, 4, total EX-stage cycles of a multiply (legal 1..16; 1 = no stall)
CNT_W, 32, width of performance counters

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  asynchronous active-low reset
start_i  input  1  pipeline run enable
IFID_RS1addr_i  input  5  rs1 of instruction in ID
IFID_RS2addr_i  input  5  rs2 of instruction in ID
IFID_useRS2_i  input  1  ID instruction reads rs2 (R-type, S-type, branch)
IDEX_MemRead_i  input  1  instruction in EX is a load
IDEX_RDaddr_i  input  5  rd of instruction in EX
IDEX_mul_i  input  1  instruction in EX is MUL (funct7=0000001)
branch_taken_i  input  1  branch in ID resolved taken
PCWrite_o  output  1  PC register write enable
IFID_write_o  output  1  IF/ID write enable
IFID_flush_o  output  1  IF/ID loads NOP
IDEX_bubble_o  output  1  ID/EX loads all-zero control
IDEX_hold_o  output  1  ID/EX keeps its contents
EXMEM_bubble_o  output  1  EX/MEM loads all-zero control
stall_cnt_o  output  CNT_W  cycles with PCWrite_o=0 while not IDLE
flush_cnt_o  output  CNT_W  cycles with IFID_flush_o=1

Behaviour:
- States: IDLE, RUN, MUL_WAIT. A 4-bit down-counter mcnt is used in MUL_WAIT.
- Reset (rst_i=0, asynchronous): state=IDLE, mcnt=0, both counters=0. Reset mid-multiply aborts it.
- All control outputs are combinational from state and inputs. Counters are registered.
- Default outputs: PCWrite=1, IFID_write=1, all others 0.
- IDLE outputs: PCWrite=0, IFID_write=0, IDEX_bubble=1, EXMEM_bubble=1.
- IDLE transition: start_i=1 at the clock edge moves to RUN.
- start_i=0 in any state moves to IDLE next cycle and clears mcnt. This has priority over every other transition.
- RUN evaluation, highest priority first:
  1. Multiply: IDEX_mul_i=1 and MUL_LAT>1. Outputs PCWrite=0, IFID_write=0, IDEX_hold=1, EXMEM_bubble=1. Next state MUL_WAIT, mcnt=MUL_LAT-1.
  2. Load-use: IDEX_MemRead_i=1, IDEX_RDaddr_i!=0, and (RDaddr==RS1addr, or IFID_useRS2_i=1 and RDaddr==RS2addr). Outputs PCWrite=0, IFID_write=0, IDEX_bubble=1. Stall is exactly 1 cycle; the branch is re-evaluated next cycle.
  3. Branch taken: outputs IFID_flush=1; the PC loads the target.
- Load-use is evaluated before branch, so a branch that depends on a load always sees the stall first.
- MUL_WAIT with mcnt>1: same outputs as the multiply case in RUN; mcnt decrements.
- MUL_WAIT with mcnt==1 (release cycle): IDEX_hold=0 and EXMEM_bubble=0, so the MUL result enters EX/MEM. The RUN load-use/branch rules apply to ID in this cycle. Next state RUN.
- The MUL occupies EX for exactly MUL_LAT cycles. With MUL_LAT=1, no MUL stall is generated.
- branch_taken_i and load-use inputs are ignored in MUL_WAIT while mcnt>1.
- stall_cnt_o increments each cycle in RUN/MUL_WAIT with PCWrite_o=0.
- flush_cnt_o increments each cycle with IFID_flush_o=1.
- Both counters wrap modulo 2^CNT_W and hold their value in IDLE.

Test Plan:
- Reset then start_i=1: cycle after start, PCWrite_o=1 and IDEX_bubble_o=0. Before start, outputs match the IDLE set and counters=0.
- Load-use: IDEX_MemRead=1, RD=5, RS1=5 -> one cycle of PCWrite=0, IFID_write=0, IDEX_bubble=1; stall_cnt_o=1. Repeat with RD=0 -> no stall.
- RS2 match: RS2=7, RD=7 with IFID_useRS2_i=0 -> no stall; with IFID_useRS2_i=1 -> stall.
- Load-use and branch_taken_i in the same cycle: only the stall asserts (IFID_flush=0). Next cycle, branch_taken_i=1 -> IFID_flush=1 and flush_cnt_o=1.
- MUL_LAT=4, IDEX_mul_i=1: IDEX_hold=1 for cycles 0..2, released at cycle 3; stall_cnt_o=3. A branch_taken_i pulse at cycle 1 produces no flush.
- start_i=0 at cycle 1 of a MUL_LAT=4 multiply -> IDLE next cycle, mcnt=0. Separately, rst_i low mid-multiply -> immediate IDLE and counters=0. Then, after forcing stall_cnt to 2^CNT_W-1 (CNT_W=8 build), one more stall gives stall_cnt_o=0.
